conv_psum_accum: RTL

- Sits directly downstream of the K-tap PE and consumes its partial_sum / partial_valid stream.
- The PE is time-multiplexed over the K kernel rows: every K consecutive valid partial sums form one output pixel.
- The block accumulates those partial sums, adds a per-channel bias, then applies round/shift requantisation, optional ReLU and int8 saturation.
- Results are buffered in a small FIFO with a valid/ready output. The PE cannot be stalled, so the FIFO absorbs output backpressure.

---
 rtl/conv_psum_accum.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/conv_psum_accum.sv
// Partial-sum accumulator for a row-multiplexed K-tap PE: sums K partial sums per pixel,
// adds bias, requantises (round/shift, ReLU, int8 saturate) and buffers results in a FIFO.
module conv_psum_accum #(
    parameter int K          = 3,
    parameter int PSUM_W     = 18,
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [PSUM_W-1:0] in_psum,
    input  logic [ACC_W-1:0]  bias,
    input  logic [4:0]        shift,
    input  logic              relu_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy,
    output logic              overflow
);

    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EXT_W = ACC_W + 1;

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(K - 1);
    localparam logic [4:0]       SH_MAX   = 5'(ACC_W - 1);
    localparam logic [AW:0]      DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(2 ** (OUT_W - 1)));

    // ------------------------------------------------------------------
    // Accumulate stage
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] row_cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] psum_ext;
    logic [4:0]       shift_eff;

    logic             sa_valid;
    logic [ACC_W-1:0] sa_sum;
    logic [4:0]       sa_shift;
    logic             sa_relu;

    assign psum_ext  = {{(ACC_W - PSUM_W){in_psum[PSUM_W-1]}}, in_psum};
    assign shift_eff = (shift > SH_MAX) ? SH_MAX : shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt  <= '0;
            acc      <= '0;
            sa_valid <= 1'b0;
            sa_sum   <= '0;
            sa_shift <= '0;
            sa_relu  <= 1'b0;
        end else if (clear) begin
            row_cnt  <= '0;
            acc      <= '0;
            sa_valid <= 1'b0;
        end else begin
            sa_valid <= 1'b0;
            if (in_valid) begin
                if (row_cnt == LAST_ROW) begin
                    sa_sum   <= acc + psum_ext + bias;
                    sa_shift <= shift_eff;
                    sa_relu  <= relu_en;
                    sa_valid <= 1'b1;
                    acc      <= '0;
                    row_cnt  <= '0;
                end else begin
                    acc     <= acc + psum_ext;
                    row_cnt <= row_cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (row_cnt != '0) || sa_valid;

    // ------------------------------------------------------------------
    // Requantisation (combinational from stage A)
    // ------------------------------------------------------------------
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] half;
    logic signed [EXT_W-1:0] sum_g;
    logic signed [EXT_W-1:0] rnd;
    logic        [OUT_W-1:0] q;

    // One guard bit above ACC_W keeps the rounding add from wrapping.
    always_comb begin
        ext   = {sa_sum[ACC_W-1], sa_sum};
        half  = '0;
        sum_g = ext;
        rnd   = ext;
        if (sa_shift != 5'd0) begin
            half  = EXT_W'(1) << (sa_shift - 5'd1);
            sum_g = ext + half;
            rnd   = sum_g >>> sa_shift;
        end
        if (sa_relu && rnd[EXT_W-1]) begin
            rnd = '0;
        end
        if (rnd > SAT_MAX) begin
            q = SAT_MAX[OUT_W-1:0];
        end else if (rnd < SAT_MIN) begin
            q = SAT_MIN[OUT_W-1:0];
        end else begin
            q = rnd[OUT_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO. Handshake: a word transfers on a rising edge where
    // out_valid && out_ready; out_data is held stable while stalled.
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign full      = (count == DEPTH_C);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push      = sa_valid && (!full || pop);
    assign drop      = sa_valid && full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
